// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // R/I-type funct3 values this core can execute
  function automatic logic funct3_supported(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's coarse ALU request plus instruction fields to an ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type; addi never subtracts
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives all datapath selects and strobes.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       retire,
  output logic       halted
);

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Outputs decode from the state; reset forces everything quiet in the same cycle
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    retire     = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
          case (op)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_R:         next_state = funct3_supported(funct3) ? S_EXECR : S_HALT;
            OP_I:         next_state = funct3_supported(funct3) ? S_EXECI : S_HALT;
            OP_JAL:       next_state = S_JAL;
            OP_BEQ:       next_state = S_BEQ;
            default:      next_state = S_HALT;
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          imm_src    = (op == OP_SW) ? IMM_S : IMM_I;
          next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end
        S_EXECR: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_RD2;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          imm_src    = IMM_I;
          alu_op     = ALUOP_FUNCT;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          pc_write   = 1'b1;
          next_state = S_ALUWB;
        end
        S_BEQ: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_RD2;
          alu_op     = ALUOP_SUB;
          pc_write   = zero;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: next_state = S_HALT;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, corner sequences
// and randomized instruction streams against a per-instruction cycle-script model.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       retire, halted;

  int checks = 0;
  int errors = 0;
  logic [18:0] got;
  logic [18:0] last;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  assign got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control, retire, halted};

  // Build an expected output vector in the same field order as got
  function automatic logic [18:0] ev(input logic req, input logic wr, input logic adr,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ret, input logic hlt);
    return {req, wr, adr, irw, pcw, rgw, rs, sa, sb, imm, alu, ret, hlt};
  endfunction

  function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs after the falling edge, compare outputs 2ns later
  task automatic step(input logic rst, input logic rdy, input logic z,
                      input logic [18:0] exp, input string nm);
    @(negedge clk);
    reset = rst; mem_ready = rdy; zero = z;
    #2;
    checks++;
    last = got;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,1), "halt");
    step(1'b0, rb(), rb(), '0, "reset_from_halt");
  endtask

  // Run one instruction from FETCH to retire (or into HALT then reset)
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm,
                           output int cyc, output logic [2:0] alu_seen);
    logic [2:0] a;
    logic       ok_f3;
    op = o; funct3 = f3; funct7b5 = f7;
    cyc = 0; alu_seen = 3'd0;
    ok_f3 = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    for (int i = 0; i < wf; i++) begin
      step(1'b1, 1'b0, rb(), ev(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0), "fetch_wait");
      cyc++;
    end
    step(1'b1, 1'b1, rb(), ev(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0), "fetch");
    cyc++;
    step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,3'd0,0,0), "decode");
    cyc++;
    if (o == T_LW) begin
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0,0), "memadr_lw");
      cyc++;
      for (int i = 0; i < wm; i++) begin
        step(1'b1, 1'b0, rb(), ev(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0), "memread_wait");
        cyc++;
      end
      step(1'b1, 1'b1, rb(), ev(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0), "memread");
      cyc++;
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,3'd0,1,0), "memwb");
      cyc++;
    end else if (o == T_SW) begin
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'd0,0,0), "memadr_sw");
      cyc++;
      for (int i = 0; i < wm; i++) begin
        step(1'b1, 1'b0, rb(), ev(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0), "memwrite_wait");
        cyc++;
      end
      step(1'b1, 1'b1, rb(), ev(1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,1,0), "memwrite");
      cyc++;
    end else if ((o == T_R || o == T_I) && ok_f3) begin
      a = alu_ref(o == T_R, f3, f7);
      if (o == T_R)
        step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,a,0,0), "exec_r");
      else
        step(1'b1, rb(), rb(), ev(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,a,0,0), "exec_i");
      alu_seen = last[4:2];
      cyc++;
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd0,1,0), "aluwb");
      cyc++;
    end else if (o == T_JAL) begin
      step(1'b1, rb(), rb(), ev(0,0,0,0,1,0,2'd0,2'd1,2'd2,2'd0,3'd0,0,0), "jal");
      cyc++;
      step(1'b1, rb(), rb(), ev(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd0,1,0), "jal_wb");
      cyc++;
    end else if (o == T_BEQ) begin
      step(1'b1, rb(), z, ev(0,0,0,0,z,0,2'd0,2'd2,2'd0,2'd0,3'd1,1,0), "beq");
      alu_seen = last[4:2];
      cyc++;
    end else begin
      halt_then_reset(3 + wm);
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         wf;
    int         wm;
    int         cycles;
    logic       chk_alu;
    logic [2:0] alu;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int         cyc;
    logic [2:0] alu_seen;
    logic [6:0] rop;
    logic [2:0] rf3;
    int         k;

    tbl[0] = '{T_LW,  3'd2, 1'b0, 1'b0, 0, 0, 5, 1'b0, 3'd0};
    tbl[1] = '{T_SW,  3'd2, 1'b0, 1'b0, 0, 2, 6, 1'b0, 3'd0};
    tbl[2] = '{T_BEQ, 3'd0, 1'b0, 1'b1, 0, 0, 3, 1'b1, 3'b001};
    tbl[3] = '{T_BEQ, 3'd0, 1'b0, 1'b0, 0, 0, 3, 1'b1, 3'b001};
    tbl[4] = '{T_R,   3'd0, 1'b1, 1'b0, 0, 0, 4, 1'b1, 3'b001};
    tbl[5] = '{T_I,   3'd0, 1'b1, 1'b0, 0, 0, 4, 1'b1, 3'b000};
    tbl[6] = '{T_R,   3'd7, 1'b0, 1'b0, 0, 0, 4, 1'b1, 3'b010};
    tbl[7] = '{T_JAL, 3'd0, 1'b0, 1'b0, 0, 0, 4, 1'b0, 3'd0};
    tbl[8] = '{T_LW,  3'd2, 1'b0, 1'b0, 1, 2, 8, 1'b0, 3'd0};

    reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    step(1'b0, 1'b1, 1'b1, '0, "reset_0");
    step(1'b0, 1'b0, 1'b0, '0, "reset_1");

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].wf, tbl[i].wm, cyc, alu_seen);
      checks++;
      if (cyc != tbl[i].cycles) begin
        errors++;
        $display("FAIL tbl%0d_latency: got %0d cycles required %0d", i, cyc, tbl[i].cycles);
      end
      if (tbl[i].chk_alu) begin
        checks++;
        if (alu_seen !== tbl[i].alu) begin
          errors++;
          $display("FAIL tbl%0d_alu: got %03b required %03b", i, alu_seen, tbl[i].alu);
        end
      end
    end

    // Illegal opcode: 10 halted cycles, then a one-cycle reset recovers
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 7, cyc, alu_seen);
    run_instr(T_R, 3'd6, 1'b0, 1'b0, 0, 0, cyc, alu_seen);
    // R-type with unsupported funct3 also halts
    run_instr(T_R, 3'd1, 1'b0, 1'b0, 0, 0, cyc, alu_seen);

    // Reset while MEMREAD is waiting on memory
    op = T_LW; funct3 = 3'd2; funct7b5 = 1'b0;
    step(1'b1, 1'b1, 1'b0, ev(1,0,0,1,1,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0), "hs_fetch");
    step(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,3'd0,0,0), "hs_decode");
    step(1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0,0), "hs_memadr");
    step(1'b1, 1'b0, 1'b0, ev(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0), "hs_memread");
    step(1'b0, 1'b0, 1'b0, '0, "hs_reset");
    step(1'b1, 1'b0, 1'b0, ev(1,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0,0), "hs_after_reset");
    run_instr(T_SW, 3'd2, 1'b0, 1'b0, 0, 1, cyc, alu_seen);

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rf3 = 3'd0;
        1: rf3 = 3'd2;
        2: rf3 = 3'd6;
        default: rf3 = 3'd7;
      endcase
      if (k < 4)       rop = T_LW;
      else if (k < 7)  rop = T_SW;
      else if (k < 10) rop = T_R;
      else if (k < 13) rop = T_I;
      else if (k < 15) rop = T_JAL;
      else if (k < 18) rop = T_BEQ;
      else if (k == 18) begin
        rop = 7'($urandom);
        if (rop == T_LW || rop == T_SW || rop == T_R || rop == T_I ||
            rop == T_JAL || rop == T_BEQ)
          rop = 7'b1111111;
      end else begin
        rop = rb() ? T_R : T_I;
        rf3 = rb() ? 3'd1 : 3'd5;
      end
      run_instr(rop, rf3, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                cyc, alu_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
